// File: rtl/csa_result_checker.sv
// rtl/csa_result_checker.sv - response monitor for the 4-operand carry-save adder
// Computes the golden sum per issued operand set, aligns it with the adder response and keeps statistics.
module csa_result_checker #(
    parameter int DATA_W      = 4,
    parameter int LATENCY     = 0,
    parameter int NUM_VECTORS = 76,
    parameter int CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    input  logic [DATA_W-1:0] d_i,
    input  logic [DATA_W:0]   rsp_s_i,
    input  logic              rsp_c_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              mismatch_o,
    output logic [CNT_W-1:0]  pass_cnt_o,
    output logic [CNT_W-1:0]  fail_cnt_o,
    output logic              first_fail_valid_o,
    output logic [CNT_W-1:0]  first_fail_idx_o,
    output logic [DATA_W+1:0] first_fail_exp_o,
    output logic [DATA_W+1:0] first_fail_got_o
);

    localparam int EXP_W = DATA_W + 2;
    localparam logic [CNT_W-1:0] NV_C  = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   issued, checked;
    logic               start_acc, issue, out_valid, compare, match, last_check;
    logic [EXP_W-1:0]   issue_exp, out_exp, got;
    logic [CNT_W-1:0]   out_idx;

    assign start_acc  = start_i && (state != RUN);
    assign issue      = (state == RUN) && in_valid_i && (issued < NV_C);
    assign issue_exp  = EXP_W'(a_i) + EXP_W'(b_i) + EXP_W'(c_i) + EXP_W'(d_i);
    assign got        = {rsp_c_i, rsp_s_i};
    assign compare    = out_valid && (state == RUN);
    assign match      = (got == out_exp);
    assign last_check = (checked == NV_C - ONE_C);

    // Golden sum, its index and a valid bit travel together to line up with the adder response.
    generate
        if (LATENCY == 0) begin : g_nodelay
            assign out_valid = issue;
            assign out_exp   = issue_exp;
            assign out_idx   = issued;
        end else begin : g_delay
            logic             dl_valid [LATENCY];
            logic [EXP_W-1:0] dl_exp   [LATENCY];
            logic [CNT_W-1:0] dl_idx   [LATENCY];

            always_ff @(posedge clk_i) begin
                if (rst_i || start_acc) begin
                    for (int i = 0; i < LATENCY; i++) dl_valid[i] <= 1'b0;
                end else begin
                    dl_valid[0] <= issue;
                    for (int i = 1; i < LATENCY; i++) dl_valid[i] <= dl_valid[i-1];
                end
            end

            always_ff @(posedge clk_i) begin
                dl_exp[0] <= issue_exp;
                dl_idx[0] <= issued;
                for (int i = 1; i < LATENCY; i++) begin
                    dl_exp[i] <= dl_exp[i-1];
                    dl_idx[i] <= dl_idx[i-1];
                end
            end

            assign out_valid = dl_valid[LATENCY-1];
            assign out_exp   = dl_exp[LATENCY-1];
            assign out_idx   = dl_idx[LATENCY-1];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = RUN;
            RUN:     if (compare && last_check) state_next = DONE;
            DONE:    if (start_i) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || start_acc) begin
            issued             <= '0;
            checked            <= '0;
            pass_cnt_o         <= '0;
            fail_cnt_o         <= '0;
            mismatch_o         <= 1'b0;
            first_fail_valid_o <= 1'b0;
            first_fail_idx_o   <= '0;
            first_fail_exp_o   <= '0;
            first_fail_got_o   <= '0;
        end else begin
            mismatch_o <= 1'b0;
            if (issue) issued <= issued + ONE_C;
            if (compare) begin
                checked <= checked + ONE_C;
                if (match) begin
                    if (pass_cnt_o != '1) pass_cnt_o <= pass_cnt_o + ONE_C;
                end else begin
                    if (fail_cnt_o != '1) fail_cnt_o <= fail_cnt_o + ONE_C;
                    mismatch_o <= 1'b1;
                    if (!first_fail_valid_o) begin
                        first_fail_valid_o <= 1'b1;
                        first_fail_idx_o   <= out_idx;
                        first_fail_exp_o   <= out_exp;
                        first_fail_got_o   <= got;
                    end
                end
            end
        end
    end

    assign busy_o = (state == RUN);
    assign done_o = (state == DONE);
    assign pass_o = (state == DONE) && (fail_cnt_o == '0);

endmodule

// File: tb/tb_csa_result_checker.sv
// tb/tb_csa_result_checker.sv - bench for csa_result_checker at LATENCY 0 and LATENCY 3
// One instance sees a combinational adder with injectable errors, the other a 3-stage pipelined adder.
module tb_csa_result_checker;

    localparam int NV = 76;

    typedef struct {
        logic [3:0] a, b, c, d;
        int         rsp;
        int         exp_sum;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [3:0] a = '0, b = '0, c = '0, d = '0;
    logic [5:0] rsp0 = '0;
    logic [5:0] pipe [3];
    int         cyc = 0;

    logic        busy0, done0, pass0, mis0, ffv0;
    logic [15:0] pcnt0, fcnt0, ffi0;
    logic [5:0]  ffe0, ffg0;
    logic        busy1, done1, pass1, mis1, ffv1;
    logic [15:0] pcnt1, fcnt1, ffi1;
    logic [5:0]  ffe1, ffg1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        pipe[0] <= 6'(int'(a) + int'(b) + int'(c) + int'(d));
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
    end

    csa_result_checker #(.DATA_W(4), .LATENCY(0), .NUM_VECTORS(NV), .CNT_W(16)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
        .a_i(a), .b_i(b), .c_i(c), .d_i(d),
        .rsp_s_i(rsp0[4:0]), .rsp_c_i(rsp0[5]),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .mismatch_o(mis0),
        .pass_cnt_o(pcnt0), .fail_cnt_o(fcnt0),
        .first_fail_valid_o(ffv0), .first_fail_idx_o(ffi0),
        .first_fail_exp_o(ffe0), .first_fail_got_o(ffg0)
    );

    csa_result_checker #(.DATA_W(4), .LATENCY(3), .NUM_VECTORS(NV), .CNT_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
        .a_i(a), .b_i(b), .c_i(c), .d_i(d),
        .rsp_s_i(pipe[2][4:0]), .rsp_c_i(pipe[2][5]),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .mismatch_o(mis1),
        .pass_cnt_o(pcnt1), .fail_cnt_o(fcnt1),
        .first_fail_valid_o(ffv1), .first_fail_idx_o(ffi1),
        .first_fail_exp_o(ffe1), .first_fail_got_o(ffg1)
    );

    int   n_pass = 0, n_total = 0;
    int   mp, mf, ffi, ffe, ffg;
    bit   ffv;
    int   ipos[$];
    vec_t tab[12];

    task automatic check(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transactions whose response has come out of the 3-stage pipeline and been counted by now.
    function automatic int exp_l3();
        int n = 0;
        foreach (ipos[k]) if (ipos[k] + 3 <= cyc) n++;
        return n;
    endfunction

    task automatic do_start();
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        mp = 0; mf = 0; ffv = 0; ffi = 0; ffe = 0; ffg = 0;
        ipos.delete();
        check("start_busy0", busy0, 1);
        check("start_busy1", busy1, 1);
        check("start_pcnt0", pcnt0, 0);
        check("start_ffv0", ffv0, 0);
    endtask

    task automatic run(input int tab_lo, input int tab_n, input bit gaps, input int n_stop);
        int   issued, guard, e, g;
        bit   iss;
        vec_t v;
        issued = 0;
        guard  = 0;
        while (issued < n_stop && guard < 2000) begin
            guard++;
            iss = !(gaps && ($urandom_range(0, 3) == 0));
            e = 0;
            g = 0;
            if (iss) begin
                if (issued < tab_n) begin
                    v = tab[tab_lo + issued];
                    a = v.a; b = v.b; c = v.c; d = v.d;
                    e = v.exp_sum;
                    g = v.rsp;
                end else begin
                    a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
                    e = int'(a) + int'(b) + int'(c) + int'(d);
                    g = e;
                end
                rsp0     = 6'(g);
                in_valid = 1'b1;
                ipos.push_back(cyc + 1);
            end else begin
                in_valid = 1'b0;
                a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
                rsp0 = 6'($urandom);
            end
            tick();
            if (iss) begin
                if (g == e) mp++;
                else begin
                    mf++;
                    if (!ffv) begin
                        ffv = 1; ffi = issued; ffe = e; ffg = g;
                    end
                end
                issued++;
            end
            check("mismatch0", mis0, (iss && g != e) ? 1 : 0);
            check("pass_cnt0", pcnt0, mp);
            check("fail_cnt0", fcnt0, mf);
            check("done0", done0, (issued == NV) ? 1 : 0);
            check("pass_cnt1_timing", pcnt1, exp_l3());
        end
        in_valid = 1'b0;
        if (guard >= 2000) check("run_budget", guard, 0);
    endtask

    task automatic finish_run(input int exp_pass, input int exp_fail, input bit exp_pass_o);
        for (int k = 0; k < 10 && !done1; k++) begin
            tick();
            check("pass_cnt1_drain", pcnt1, exp_l3());
            check("done0_hold", done0, 1);
        end
        check("done1", done1, 1);
        check("busy1", busy1, 0);
        check("final_pcnt1", pcnt1, NV);
        check("final_fcnt1", fcnt1, 0);
        check("final_pass1", pass1, 1);
        check("final_pcnt0", pcnt0, exp_pass);
        check("final_fcnt0", fcnt0, exp_fail);
        check("final_pass0", pass0, exp_pass_o);
        check("final_busy0", busy0, 0);
        check("final_ffv0", ffv0, ffv);
        if (ffv) begin
            check("final_ffi0", ffi0, ffi);
            check("final_ffe0", ffe0, ffe);
            check("final_ffg0", ffg0, ffg);
        end
    endtask

    initial begin
        tab[0]  = '{4'hF, 4'hF, 4'hF, 4'hF, 60, 60};
        tab[1]  = '{4'hF, 4'hF, 4'hF, 4'hF, 59, 60};
        tab[2]  = '{4'h0, 4'h0, 4'h0, 4'h0,  0,  0};
        tab[3]  = '{4'h1, 4'h2, 4'h3, 4'h4, 10, 10};
        tab[4]  = '{4'h8, 4'h8, 4'h8, 4'h8, 32, 32};
        tab[5]  = '{4'hF, 4'h0, 4'hF, 4'h0, 30, 30};
        tab[6]  = '{4'h7, 4'h7, 4'h7, 4'h7, 28, 28};
        tab[7]  = '{4'h3, 4'h3, 4'h3, 4'h3, 13, 12};
        tab[8]  = '{4'hA, 4'h5, 4'hA, 4'h5, 30, 30};
        tab[9]  = '{4'h1, 4'h1, 4'h1, 4'h1,  4,  4};
        tab[10] = '{4'hE, 4'hD, 4'hC, 4'hB, 50, 50};
        tab[11] = '{4'h9, 4'h9, 4'h9, 4'h9, 32, 36};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
            rsp0 = 6'($urandom);
            tick();
            check("idle_busy0", busy0, 0);
            check("idle_pcnt0", pcnt0, 0);
            check("idle_fcnt0", fcnt0, 0);
            check("idle_mis0", mis0, 0);
        end
        check("idle_done0", done0, 0);
        check("idle_pass0", pass0, 0);
        check("idle_ffv0", ffv0, 0);
        check("idle_ffi0", ffi0, 0);
        check("idle_ffe0", ffe0, 0);
        check("idle_ffg0", ffg0, 0);
        check("idle_pcnt1", pcnt1, 0);

        start    = 1'b1;
        in_valid = 1'b1;
        rsp0     = 6'd63;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("startvalid_busy0", busy0, 1);
        check("startvalid_pcnt0", pcnt0, 0);
        check("startvalid_fcnt0", fcnt0, 0);
        check("startvalid_pcnt1", pcnt1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        do_start();
        run(0, 1, 1'b0, NV);
        finish_run(NV, 0, 1'b1);

        do_start();
        run(1, 1, 1'b1, NV);
        finish_run(NV - 1, 1, 1'b0);
        check("max_ffi0", ffi0, 0);
        check("max_ffe0", ffe0, 60);
        check("max_ffg0", ffg0, 59);

        do_start();
        run(2, 10, 1'b1, NV);
        finish_run(NV - 2, 2, 1'b0);
        check("multi_ffi0", ffi0, 5);
        check("multi_ffe0", ffe0, 12);
        check("multi_ffg0", ffg0, 13);

        do_start();
        run(0, 0, 1'b1, 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_pcnt0", pcnt0, 0);
        check("abort_busy0", busy0, 0);
        check("abort_pcnt1", pcnt1, 0);
        check("abort_busy1", busy1, 0);
        for (int k = 0; k < 5; k++) tick();
        check("abort_inflight_pcnt1", pcnt1, 0);
        check("abort_inflight_fcnt1", fcnt1, 0);
        do_start();
        run(0, 0, 1'b1, NV);
        finish_run(NV, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
